gpio_checker: RTL and testbench
===============================

GPIO_CHECKER -- requirements
Module: gpio_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the monitored bus and of the expected values.
REQ-002 Parameter DEPTH, default 32, power of two, SHALL set the number of expectation entries.
REQ-003 Parameter DELAY_WIDTH, default 8, SHALL set the width of the per-entry cycle delay.
REQ-004 Ports SHALL be:
  clk         in   1                  sole clock, rising edge
  reset       in   1                  synchronous, active-high
  gpio        in   DATA_WIDTH         bus under test
  wr_en       in   1                  table write strobe
  wr_addr     in   log2(DEPTH)        entry index
  wr_data     in   DATA_WIDTH         expected value
  wr_mask     in   DATA_WIDTH         compare mask, 1 = bit checked
  wr_delay    in   DELAY_WIDTH        cycles since previous check
  wr_last     in   1                  entry terminates the sequence
  start       in   1                  begin sequence at entry 0
  busy        out  1                  sequence in progress
  done        out  1                  sequence finished, level
  pass        out  1                  all checks matched, valid when done
  fail_idx    out  log2(DEPTH)        first failing entry
  fail_actual out  DATA_WIDTH         gpio value at first failure
  err_count   out  log2(DEPTH)+1      mismatch count (GPIO_CHECKER_CONT_EN only)
REQ-005 One clock (clk); reset is synchronous and active-high.

Function
REQ-006 States SHALL be IDLE, WAIT, CHECK, FINISH.
REQ-007 wr_en in IDLE or FINISH SHALL write {wr_data, wr_mask, wr_delay, wr_last} to entry wr_addr at the edge; wr_en while busy SHALL be ignored.
REQ-008 start in IDLE or FINISH, sampled at edge T, SHALL clear done, pass, fail_idx, fail_actual, err_count, set busy, select entry 0, load delay counter with delay_0, enter WAIT.
REQ-009 start while busy SHALL be ignored.
REQ-010 A stored delay of 0 SHALL behave as 1.
REQ-011 Entry 0 SHALL be compared against gpio sampled at edge T + delay_0; entry k>0 at edge (compare edge of k-1) + delay_k.
REQ-012 Match SHALL be ((gpio ^ data) & mask) == 0; mask 0 always matches.
REQ-013 On first mismatch fail_idx and fail_actual SHALL capture entry index and gpio at that edge and SHALL hold until next start.
REQ-014 After comparing an entry with last=1, or entry DEPTH-1 (index wrap forbidden), FSM SHALL enter FINISH: busy=0, done=1, pass=1 iff no mismatch.
REQ-015 Mismatch and last on the same entry SHALL record the failure and finish in that one edge.
REQ-016 FINISH SHALL hold outputs until start or reset.

Reset
REQ-017 reset SHALL force IDLE; busy, done, pass, fail_idx, fail_actual, err_count SHALL be 0.
REQ-018 reset mid-sequence SHALL abort without setting done; table contents SHALL be retained (not reset).
REQ-019 reset SHALL take priority over start and wr_en in the same cycle.

Configuration
REQ-020 Macro GPIO_CHECKER_CONT_EN defined: sequence SHALL continue past mismatches to the last entry; err_count SHALL increment per mismatch, saturating at DEPTH.
REQ-021 Macro undefined: first mismatch SHALL enter FINISH immediately with pass=0; err_count SHALL be tied 0.

Structure
REQ-022 Package gpio_checker_pkg SHALL hold the state enum and the entry struct {data, mask, delay, last}.
REQ-023 Table SHALL be sub-module gpio_checker_table: one synchronous write port, one combinational read port, no reset.

Verification
REQ-024 Entries {FFFFFFFF,all-ones,14}, {1,all-ones,1,last}; gpio drives matching values at T+14, T+15 -> done=1, pass=1 at edge T+15, busy=0.
REQ-025 Entry 1 expects 6, gpio=7 at compare edge -> pass=0, fail_idx=1, fail_actual=7; without macro done at that edge, with macro sequence continues, err_count=1.
REQ-026 Mask 0000FFFF, data 0000700A, gpio ABCD700A -> match; gpio ABCD700B -> mismatch.
REQ-027 Delay 0 entry -> compared one edge after previous; no entry with last=1 -> finishes after entry DEPTH-1.
REQ-028 reset asserted mid-WAIT -> next cycle IDLE, all outputs 0; new start replays the retained table and passes.
REQ-029 wr_en and start during busy -> table unchanged, sequence timing unchanged.

Source files
------------

// File: rtl/gpio_checker_pkg.sv
// gpio_checker_pkg
//   Shared types for the GPIO sequence checker:
//     state_t  - sequencer states (IDLE, WAIT, CHECK, FINISH)
//     entry_t  - one expectation-table entry {data, mask, delay, last}
//   Entry fields are sized at the widest supported configuration
//   (MAX_DATA_W / MAX_DELAY_W). The top zero-extends narrower values, so
//   the unused upper bits are constant and drop out in synthesis.
package gpio_checker_pkg;

  localparam int MAX_DATA_W  = 64;
  localparam int MAX_DELAY_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0]  data;
    logic [MAX_DATA_W-1:0]  mask;
    logic [MAX_DELAY_W-1:0] delay;
    logic                   last;
  } entry_t;

  // A stored delay of zero is treated as one cycle.
  function automatic logic [MAX_DELAY_W-1:0] eff_delay(input logic [MAX_DELAY_W-1:0] d);
    return (d == '0) ? MAX_DELAY_W'(1) : d;
  endfunction

endpackage

// File: rtl/gpio_checker_table.sv
// gpio_checker_table
//   Expectation table: DEPTH entries of entry_t, one synchronous write
//   port and one combinational read port. Contents are not reset, so a
//   programmed sequence survives a reset of the sequencer.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable (already qualified by the caller)
//   waddr  - write index
//   wdata  - entry written at the edge
//   raddr  - read index
//   rdata  - entry at raddr, combinational
module gpio_checker_table
  import gpio_checker_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpio_checker.sv
// gpio_checker
//   Plays a programmed sequence of masked expectations against a GPIO bus.
//   Each entry is compared 'delay' edges after the previous compare (or
//   after the start edge for entry 0); a delay of 0 acts as 1.
//   The sequence ends after an entry flagged 'last' or after entry DEPTH-1.
//
//   Handshake: start and wr_en are single-cycle strobes sampled at the
//   rising edge and honoured only while not busy (IDLE or FINISH); both are
//   ignored while busy and while reset is high. done/pass are levels that
//   hold until the next accepted start or reset.
//
//   Build option GPIO_CHECKER_CONT_EN:
//     defined   - run through mismatches to the end, count them in
//                 err_count (saturating at DEPTH)
//     undefined - stop at the first mismatch, err_count tied to 0
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   gpio                   - bus under test
//   wr_en/wr_addr/wr_data/ - table write: expected value, compare mask
//   wr_mask/wr_delay/        (1 = bit checked), delay from previous check,
//   wr_last                  end-of-sequence flag
//   start                  - begin sequence at entry 0
//   busy, done, pass       - status (pass valid when done)
//   fail_idx, fail_actual  - first failing entry and gpio value seen there
//   err_count              - mismatch count
module gpio_checker
  import gpio_checker_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int DELAY_WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  gpio,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [DATA_WIDTH-1:0]  wr_mask,
  input  logic [DELAY_WIDTH-1:0] wr_delay,
  input  logic                   wr_last,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [AW-1:0]          fail_idx,
  output logic [DATA_WIDTH-1:0]  fail_actual,
  output logic [AW:0]            err_count
);

  state_t                 state_q;
  logic [AW-1:0]          idx_q;
  logic [MAX_DELAY_W-1:0] cnt_q;
  logic [MAX_DATA_W-1:0]  cur_data_q;
  logic [MAX_DATA_W-1:0]  cur_mask_q;
  logic                   cur_last_q;
  logic                   fail_seen_q;

  entry_t                 wr_entry;
  entry_t                 rd_entry;
  logic [AW-1:0]          rd_addr;
  logic [MAX_DELAY_W-1:0] rd_delay;
  logic [MAX_DATA_W-1:0]  gpio_ext;
  logic                   idle_like;
  logic                   mismatch;
  logic                   last_cmp;
  logic                   stop;

  assign idle_like = (state_q == IDLE) || (state_q == FINISH);

  assign wr_entry = '{data:  MAX_DATA_W'(wr_data),
                      mask:  MAX_DATA_W'(wr_mask),
                      delay: MAX_DELAY_W'(wr_delay),
                      last:  wr_last};

  // The single read port serves two purposes: while waiting it shows the
  // entry about to enter CHECK; during CHECK the entry under test is held
  // in cur_*_q, so the port looks ahead to the next entry to load its delay.
  always_comb begin
    rd_addr = '0;
    case (state_q)
      WAIT:    rd_addr = idx_q;
      CHECK:   rd_addr = idx_q + AW'(1);
      default: rd_addr = '0;
    endcase
  end

  gpio_checker_table #(.DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .we    (wr_en && idle_like && !reset),
    .waddr (wr_addr),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  assign rd_delay = eff_delay(rd_entry.delay);
  assign gpio_ext = MAX_DATA_W'(gpio);
  assign mismatch = |((gpio_ext ^ cur_data_q) & cur_mask_q);
  assign last_cmp = cur_last_q || (idx_q == AW'(DEPTH - 1));

`ifdef GPIO_CHECKER_CONT_EN
  assign stop = last_cmp;
  logic [AW:0] err_q;
  assign err_count = err_q;
`else
  assign stop = last_cmp || mismatch;
  assign err_count = '0;
`endif

  // cnt_q holds the number of edges left until the compare edge of the
  // current entry. WAIT hands over to CHECK when one edge remains, so the
  // compare itself always happens on an edge spent in CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      cur_data_q  <= '0;
      cur_mask_q  <= '0;
      cur_last_q  <= 1'b0;
      fail_seen_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_idx    <= '0;
      fail_actual <= '0;
`ifdef GPIO_CHECKER_CONT_EN
      err_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          if (start) begin
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_idx    <= '0;
            fail_actual <= '0;
            fail_seen_q <= 1'b0;
`ifdef GPIO_CHECKER_CONT_EN
            err_q       <= '0;
`endif
            idx_q       <= '0;
            cnt_q       <= rd_delay;
            cur_data_q  <= rd_entry.data;
            cur_mask_q  <= rd_entry.mask;
            cur_last_q  <= rd_entry.last;
            state_q     <= (rd_delay == MAX_DELAY_W'(1)) ? CHECK : WAIT;
          end
        end

        WAIT: begin
          cnt_q <= cnt_q - MAX_DELAY_W'(1);
          if (cnt_q == MAX_DELAY_W'(2)) begin
            cur_data_q <= rd_entry.data;
            cur_mask_q <= rd_entry.mask;
            cur_last_q <= rd_entry.last;
            state_q    <= CHECK;
          end
        end

        CHECK: begin
          if (mismatch && !fail_seen_q) begin
            fail_seen_q <= 1'b1;
            fail_idx    <= idx_q;
            fail_actual <= gpio;
          end
`ifdef GPIO_CHECKER_CONT_EN
          if (mismatch && (err_q != (AW+1)'(DEPTH))) begin
            err_q <= err_q + (AW+1)'(1);
          end
`endif
          if (stop) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= !(mismatch || fail_seen_q);
            state_q <= FINISH;
          end else begin
            idx_q      <= idx_q + AW'(1);
            cnt_q      <= rd_delay;
            cur_data_q <= rd_entry.data;
            cur_mask_q <= rd_entry.mask;
            cur_last_q <= rd_entry.last;
            state_q    <= (rd_delay == MAX_DELAY_W'(1)) ? CHECK : WAIT;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_checker.sv
// tb_gpio_checker
//   Bench for gpio_checker with default parameters. A per-cycle gpio
//   schedule and a mirror of the programmed table feed a reference model
//   that pushes the expected outcome of each sequence into exp_q; the
//   outcome is popped and compared when the DUT raises done.
//   Honours GPIO_CHECKER_CONT_EN the same way the design does.
module tb_gpio_checker;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int DLW   = 8;
  localparam int AW    = 5;
  localparam int EXP_W = 72;
  localparam int SCHED = 1024;

`ifdef GPIO_CHECKER_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [DW-1:0]  gpio;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [DW-1:0]  wr_mask;
  logic [DLW-1:0] wr_delay;
  logic           wr_last;
  logic           start;
  logic           busy;
  logic           done;
  logic           pass;
  logic [AW-1:0]  fail_idx;
  logic [DW-1:0]  fail_actual;
  logic [AW:0]    err_count;

  logic [DW-1:0]  m_data  [DEPTH];
  logic [DW-1:0]  m_mask  [DEPTH];
  logic [DLW-1:0] m_delay [DEPTH];
  logic           m_last  [DEPTH];
  logic [DW-1:0]  sched   [SCHED];

  logic [EXP_W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  gpio_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DELAY_WIDTH(DLW)) dut (
    .clk         (clk),
    .reset       (reset),
    .gpio        (gpio),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .wr_delay    (wr_delay),
    .wr_last     (wr_last),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_idx    (fail_idx),
    .fail_actual (fail_actual),
    .err_count   (err_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int a, input logic [DW-1:0] d, input logic [DW-1:0] m,
                             input logic [DLW-1:0] dl, input logic l);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    wr_mask  = m;
    wr_delay = dl;
    wr_last  = l;
    m_data[a]  = d;
    m_mask[a]  = m;
    m_delay[a] = dl;
    m_last[a]  = l;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill_sched();
    for (int i = 0; i < SCHED; i++) sched[i] = $urandom;
  endtask

  // Reference model: walks the mirrored table against the schedule and
  // pushes {finish_edge, pass, fail_idx, fail_actual, err_count}.
  task automatic model_push();
    int t = 0;
    int errs = 0;
    bit fs = 1'b0;
    int fi = 0;
    logic [DW-1:0] fa = '0;
    bit mm;
    for (int k = 0; k < DEPTH; k++) begin
      t += (m_delay[k] == 0) ? 1 : int'(m_delay[k]);
      mm = (((sched[t] ^ m_data[k]) & m_mask[k]) != '0);
      if (mm) begin
        if (errs < DEPTH) errs++;
        if (!fs) begin
          fs = 1'b1;
          fi = k;
          fa = sched[t];
        end
      end
      if (m_last[k] || (k == DEPTH - 1) || (!CONT && mm)) break;
    end
    if (!CONT) errs = 0;
    exp_q.push_back({16'(t), 8'(!fs), 8'(fi), fa, 8'(errs)});
  endtask

  // Runs one sequence; with inject set, a table write and a second start
  // are issued while the sequence is busy.
  task automatic run_seq(input string name, input bit inject);
    int fin = -1;
    logic [EXP_W-1:0] e;
    model_push();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < SCHED - 2; n++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (n >= 1 && done) begin
        fin = n;
        break;
      end
      if (n == 1) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s busy_running: got %b want 1", name, busy);
        end
      end
      gpio = sched[n + 1];
      if (inject && n == 2) begin
        start    = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = AW'(1);
        wr_data  = ~m_data[1];
        wr_mask  = '1;
        wr_delay = 8'd1;
        wr_last  = 1'b1;
      end
    end
    e = exp_q.pop_front();
    tests_run++;
    if (fin != int'(e[71:56])) begin
      tests_failed++;
      $display("FAIL %s finish_edge: got %0d want %0d", name, fin, e[71:56]);
    end
    if (fin < 0) return;
    tests_run++;
    if (pass !== e[48]) begin
      tests_failed++;
      $display("FAIL %s pass: got %b want %b", name, pass, e[48]);
    end
    tests_run++;
    if (fail_idx !== e[44:40]) begin
      tests_failed++;
      $display("FAIL %s fail_idx: got %0d want %0d", name, fail_idx, e[44:40]);
    end
    tests_run++;
    if (fail_actual !== e[39:8]) begin
      tests_failed++;
      $display("FAIL %s fail_actual: got %h want %h", name, fail_actual, e[39:8]);
    end
    tests_run++;
    if (err_count !== e[5:0]) begin
      tests_failed++;
      $display("FAIL %s err_count: got %0d want %0d", name, err_count, e[5:0]);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_done: got %b want 0", name, busy);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests_run++;
    if ({busy, done, pass} !== 3'b000 || fail_idx !== '0 || fail_actual !== '0 || err_count !== '0) begin
      tests_failed++;
      $display("FAIL %s outputs: got busy=%b done=%b pass=%b idx=%0d act=%h err=%0d want all 0",
               name, busy, done, pass, fail_idx, fail_actual, err_count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    fill_sched();
    write_entry(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd14, 1'b0);
    write_entry(1, 32'h0000_0001, 32'hFFFF_FFFF, 8'd1,  1'b1);
    sched[14] = 32'hFFFF_FFFF;
    sched[15] = 32'h0000_0001;
    run_seq("basic", 1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if ({done, pass} !== 2'b11) begin
      tests_failed++;
      $display("FAIL basic_hold: got done=%b pass=%b want 1 1", done, pass);
    end
  endtask

  task automatic test_mismatch();
    fill_sched();
    write_entry(0, 32'h0000_00A5, 32'h0000_00FF, 8'd3, 1'b0);
    write_entry(1, 32'h0000_0006, 32'hFFFF_FFFF, 8'd2, 1'b0);
    write_entry(2, 32'h0000_0000, 32'h0000_0000, 8'd2, 1'b1);
    sched[3] = 32'h1234_56A5;
    sched[5] = 32'h0000_0007;
    run_seq("mismatch", 1'b0);
  endtask

  task automatic test_mask();
    fill_sched();
    write_entry(0, 32'h0000_700A, 32'h0000_FFFF, 8'd2, 1'b0);
    write_entry(1, 32'h0000_700A, 32'h0000_FFFF, 8'd2, 1'b1);
    sched[2] = 32'hABCD_700A;
    sched[4] = 32'hABCD_700B;
    run_seq("mask_miss", 1'b0);
    fill_sched();
    sched[2] = 32'hABCD_700A;
    sched[4] = 32'h5555_700A;
    run_seq("mask_hit", 1'b0);
  endtask

  task automatic test_delay0_wrap();
    fill_sched();
    for (int k = 0; k < DEPTH; k++) begin
      write_entry(k, 32'h0101_0101 * k, (k % 8 == 5) ? 32'hFFFF_FFFF : 32'h0, 8'd0, 1'b0);
      sched[k + 1] = 32'h0101_0101 * k;
    end
    run_seq("wrap", 1'b0);
    sched[14] = sched[14] ^ 32'h0000_0100;
    run_seq("wrap_miss", 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_sched();
    write_entry(0, 32'h0000_0033, 32'h0000_00FF, 8'd4, 1'b0);
    write_entry(1, 32'h0000_0044, 32'h0000_00FF, 8'd5, 1'b1);
    sched[4] = 32'h0000_0033;
    sched[9] = 32'h0000_0044;
    run_seq("busy_ignore", 1'b1);
    run_seq("replay", 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = AW'(0);
    wr_data = ~m_data[0];
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    check_idle_outputs("reset_mid");
    repeat (6) @(negedge clk);
    check_idle_outputs("reset_mid_hold");
    run_seq("after_reset", 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    gpio     = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    wr_delay = '0;
    wr_last  = 1'b0;
    start    = 1'b0;
    test_reset();
    test_basic();
    test_mismatch();
    test_mask();
    test_delay0_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
